// File: rtl/uio_mem_arbiter.sv
// Purpose : shares the byte-wide uio pad bus between the core's fetch port and data port.
// Latency : handshake edge k -> rsp_valid in cycle k+9 (read) / k+8 (write); each bus_ack-low cycle adds one.
// Backpress: one transfer in flight; req_ready only in IDLE; bus stalls indefinitely while bus_ack is low.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   if_req_*/if_rsp_*           instruction-fetch port (read only)
//   d_req_*/d_rsp_*             data port (read or write)
//   bus_out/bus_oe/bus_strobe   byte, pad output enable and byte-valid toward the memory
//   bus_in/bus_ack              byte from the memory and per-byte accept/present strobe
module uio_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic [7:0]        bus_out,
  output logic [7:0]        bus_oe,
  input  logic [7:0]        bus_in,
  output logic              bus_strobe,
  input  logic              bus_ack
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, TURN, RDATA, WDATA, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q;
  logic                port_q;        // 0 = fetch, 1 = data
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rbuf_q;
  logic                last_grant_q;  // 0 = fetch, 1 = data
  logic                grant_d;
  logic                accept;

  // Data port wins when it is the only requester, or when both request and
  // fetch was served last.
  assign grant_d = d_req_valid & (~if_req_valid | ~last_grant_q);
  // Ready is combinational on valid, so any valid request in IDLE handshakes.
  assign accept  = (state_q == IDLE) & (if_req_valid | d_req_valid);

  always_comb begin
    state_d      = state_q;
    bus_out      = 8'h00;
    bus_oe       = 8'h00;
    bus_strobe   = 1'b0;
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    if_rsp_valid = 1'b0;
    d_rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if_req_ready = if_req_valid & ~grant_d;
        d_req_ready  = grant_d;
        if (accept) state_d = CMD;
      end
      CMD: begin
        bus_out    = {1'b1, we_q, 5'b00000, port_q};
        bus_oe     = 8'hFF;
        bus_strobe = 1'b1;
        if (bus_ack) state_d = ADDR_HI;
      end
      ADDR_HI: begin
        bus_out    = addr_q[15:8];
        bus_oe     = 8'hFF;
        bus_strobe = 1'b1;
        if (bus_ack) state_d = ADDR_LO;
      end
      ADDR_LO: begin
        bus_out    = addr_q[7:0];
        bus_oe     = 8'hFF;
        bus_strobe = 1'b1;
        if (bus_ack) state_d = we_q ? WDATA : TURN;
      end
      // One dead cycle so the memory can start driving the pads.
      TURN: state_d = RDATA;
      RDATA: begin
        if (bus_ack && cnt_q == 2'd3) state_d = DONE;
      end
      WDATA: begin
        bus_out    = wdata_q[{cnt_q, 3'b000} +: 8];
        bus_oe     = 8'hFF;
        bus_strobe = 1'b1;
        if (bus_ack && cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if_rsp_valid = ~port_q;
        d_rsp_valid  = port_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      last_grant_q <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_rdata  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            port_q       <= grant_d;
            we_q         <= grant_d & d_req_we;
            addr_q       <= grant_d ? d_req_addr : if_req_addr;
            wdata_q      <= d_req_wdata;
            last_grant_q <= grant_d;
            cnt_q        <= 2'd0;
          end
        end
        RDATA: begin
          if (bus_ack) begin
            rbuf_q[{cnt_q, 3'b000} +: 8] <= bus_in;
            cnt_q <= cnt_q + 2'd1;
            // Final byte goes straight into the response register so the
            // word is already visible during DONE.
            if (cnt_q == 2'd3) begin
              if (port_q) d_rsp_rdata <= {bus_in, rbuf_q[23:0]};
              else        if_rsp_data <= {bus_in, rbuf_q[23:0]};
            end
          end
        end
        WDATA: begin
          if (bus_ack) cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uio_mem_arbiter.md
Name: uio_mem_arbiter

Overview:
- Shares the 8-bit uio pad bus between the RISC-V core's instruction-fetch port and its data port.
- Sequences each 32-bit word transfer to the external byte-wide memory as: command byte, address bytes, turnaround, then data bytes.
- Sits between the core and the uio_in/uio_out/uio_oe pins in tt_um_utoss_riscv.
- Round-robin arbitration; one transfer in flight at a time.

Parameters:
- ADDR_W, 16, word address width; fixed at 16 (sent as two bytes).
- DATA_W, 32, word width; fixed at 32 (sent as four bytes).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- if_req_valid  in  1  fetch request
- if_req_addr  in  16  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  fetch data valid (1-cycle pulse)
- if_rsp_data  out  32  fetched word
- d_req_valid  in  1  data request
- d_req_we  in  1  1=write, 0=read
- d_req_addr  in  16  data address
- d_req_wdata  in  32  write word
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  data read/write complete (1-cycle pulse)
- d_rsp_rdata  out  32  read word (holds previous value after a write)
- bus_out  out  8  byte driven to pads
- bus_oe  out  8  pad output enable; 0xFF when driving, 0x00 otherwise
- bus_in  in  8  byte from pads
- bus_strobe  out  1  high while bus_out carries a valid byte
- bus_ack  in  1  external memory accepted or presented the current byte

Behaviour:
- Reset values (async, rst=1):
  - State IDLE; bus_out=0, bus_oe=0, bus_strobe=0.
  - Both ready and both rsp_valid = 0; if_rsp_data = 0, d_rsp_rdata = 0.
  - last_grant = IF.
- States: IDLE, CMD, ADDR_HI, ADDR_LO, TURN, RDATA, WDATA, DONE. A 2-bit byte counter is used in RDATA and WDATA.
- Arbitration (IDLE only):
  - Ready outputs are combinational and high only in IDLE, for the granted port.
  - If exactly one port is valid, it is granted.
  - If both are valid, the port not equal to last_grant is granted.
  - On a valid&ready handshake: latch port, we (IF reads are always we=0), addr and wdata; update last_grant; go to CMD.
  - Ready is never high outside IDLE.
- Command byte: bit7=1, bit6=we, bits5:1=0, bit0=port (0=IF, 1=data). Values: IF read 0x80, data read 0x81, data write 0xC1.
- CMD, ADDR_HI, ADDR_LO, WDATA:
  - bus_oe=0xFF, bus_strobe=1.
  - Byte is held until a cycle with bus_ack=1; advance on that edge.
  - ADDR_HI sends addr[15:8]; ADDR_LO sends addr[7:0].
  - WDATA sends wdata bytes LSB first (counter 0..3), then goes to DONE.
  - After ADDR_LO: write goes to WDATA, read goes to TURN.
- TURN: exactly one cycle; bus_oe=0, strobe=0, ack ignored; then RDATA.
- RDATA:
  - bus_oe=0, strobe=0.
  - On each cycle with bus_ack=1, capture bus_in into byte[counter] (LSB first); after byte 3 go to DONE.
- DONE: one cycle.
  - rsp_valid of the latched port = 1.
  - For reads, that port's rsp_data is updated with the assembled word, visible in the DONE cycle.
  - Writes leave rdata unchanged.
  - Next state IDLE; a new request can be accepted in the following cycle.
- Latency with bus_ack tied high, handshake at edge k:
  - Read: rsp_valid high in cycle k+9.
  - Write: rsp_valid high in cycle k+8.
  - Each ack-low cycle adds one cycle.
- Request inputs may change after the handshake without effect.
- Reset mid-transfer: immediately IDLE, bus released, no rsp pulse, transfer dropped, last_grant=IF.
- No timeout: a permanently low bus_ack stalls forever.

Test Plan:
- Reset with all valids low -> bus_oe=0x00, strobe=0, all ready/rsp=0, rsp_data=0; then if_req_valid=1 alone -> if_req_ready=1 combinationally.
- IF read addr 0x1234, ack=1, bus_in=0xEF,0xBE,0xAD,0xDE during RDATA -> strobed bytes 0x80,0x12,0x34; oe=0 from TURN on; if_rsp_valid pulse at k+9 with if_rsp_data=0xDEADBEEF.
- Data write addr 0x00F0, wdata 0xCAFEBABE, ack=1 -> bytes 0xC1,0x00,0xF0,0xBE,0xBA,0xFE,0xCA; d_rsp_valid pulse at k+8; d_rsp_rdata unchanged.
- Both ports held valid continuously from reset -> grants alternate D, IF, D, IF; each ready is a single-cycle pulse, only in IDLE.
- bus_ack low for 3 cycles during ADDR_HI of an IF read to 0x1234 -> bus_out holds 0x12 with strobe=1; rsp_valid moves to k+12.
- rst asserted during RDATA byte 1 -> same-cycle IDLE, oe=0, no rsp_valid ever; next simultaneous request is granted to D.
